// File: rtl/decade_phase_tracker_pkg.sv
// decade_phase_tracker_pkg
// Shared types and helpers for the Johnson-decade phase tracker.
//   state_t       : tracker FSM states (SYNC / TRACK / FAULT)
//   bcd_t         : one BCD digit
//   PHASE_A0      : phase code for Johnson state 0
//   phase_dec_t   : decoded phase (valid flag + index)
//   phase_decode(): one-hot to index, valid only for exactly one set bit
package decade_phase_tracker_pkg;

    typedef enum logic [1:0] {
        SYNC  = 2'd0,
        TRACK = 2'd1,
        FAULT = 2'd2
    } state_t;

    typedef logic [3:0] bcd_t;

    localparam logic [9:0] PHASE_A0 = 10'b0000000001;
    localparam bcd_t       BCD_MAX  = 4'd9;

    typedef struct packed {
        logic       valid;
        logic [3:0] idx;
    } phase_dec_t;

    function automatic phase_dec_t phase_decode(input logic [9:0] phase);
        phase_dec_t r;
        // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
        r.valid = (phase != 10'd0) && ((phase & (phase - 10'd1)) == 10'd0);
        r.idx   = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (phase[i]) begin
                r.idx = 4'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/decade_phase_tracker_bcd_decade_stage.sv
// bcd_decade_stage
// One registered BCD digit of the decade cascade.
//   clk, rst : clock, async active-high reset
//   clr      : synchronous clear of the digit
//   cin      : increment request from the stage below
//   digit    : registered BCD value 0..9
//   cout     : combinational carry, high when cin arrives while digit is 9
module bcd_decade_stage
    import decade_phase_tracker_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic cin,
    output bcd_t digit,
    output logic cout
);

    assign cout = cin && (digit == BCD_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            digit <= 4'd0;
        end else if (clr) begin
            digit <= 4'd0;
        end else if (cin) begin
            digit <= (digit == BCD_MAX) ? 4'd0 : digit + 4'd1;
        end
    end

endmodule

// File: rtl/decade_phase_tracker.sv
// decade_phase_tracker
// Samples the ten one-hot phase lines of a Johnson decade counter, checks
// that they form a legal code stepping in sequence, and counts completed
// decades into a BCD cascade.
//   clk, rst : clock, async active-high reset
//   phase    : one-hot phase, bit i set in Johnson state i
//   clr      : synchronous clear of counts and fault (highest priority)
//   units    : BCD units digit (index of last accepted phase)
//   decades  : NDEC BCD digits, [3:0] is the tens digit
//   locked   : high while tracking
//   fault    : sticky illegal code / illegal transition flag
//   wrap     : one-cycle pulse when the full count rolls all-9 -> all-0
// Build option: define PHASE_SEQ_CHECK_EN to fault on a legal but
// out-of-sequence phase; otherwise such a phase resynchronises the units.
//
// state | meaning
// SYNC  | counts held at 0, waiting for phase a0
// TRACK | following the phase sequence and counting decades
// FAULT | counts frozen, fault set, leaves only on clr or rst
module decade_phase_tracker
    import decade_phase_tracker_pkg::*;
#(
    parameter int unsigned NDEC = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [9:0]          phase,
    input  logic                clr,
    output logic [3:0]          units,
    output logic [4*NDEC-1:0]   decades,
    output logic                locked,
    output logic                fault,
    output logic                wrap
);

    state_t     state;
    logic [3:0] prev_idx;
    phase_dec_t dec;
    logic [3:0] succ_idx;
    logic       is_succ;
    logic [NDEC:0] carry;

    assign dec      = phase_decode(phase);
    assign succ_idx = (prev_idx == 4'd9) ? 4'd0 : prev_idx + 4'd1;
    assign is_succ  = dec.valid && (dec.idx == succ_idx);

    // Only an accepted 9 -> 0 step feeds the cascade; the carry ripples
    // through every stage in the same cycle.
    assign carry[0] = (state == TRACK) && !clr && is_succ && (prev_idx == 4'd9);

    for (genvar g = 0; g < NDEC; g++) begin : g_stage
        bcd_decade_stage u_stage (
            .clk   (clk),
            .rst   (rst),
            .clr   (clr),
            .cin   (carry[g]),
            .digit (decades[4*g +: 4]),
            .cout  (carry[g+1])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= SYNC;
            prev_idx <= 4'd0;
            units    <= 4'd0;
            locked   <= 1'b0;
            fault    <= 1'b0;
            wrap     <= 1'b0;
        end else if (clr) begin
            state    <= SYNC;
            prev_idx <= 4'd0;
            units    <= 4'd0;
            locked   <= 1'b0;
            fault    <= 1'b0;
            wrap     <= 1'b0;
        end else begin
            // Carry out of the top stage means every digit was 9.
            wrap <= carry[NDEC];
            case (state)
                SYNC: begin
                    if (phase == PHASE_A0) begin
                        state    <= TRACK;
                        prev_idx <= 4'd0;
                        units    <= 4'd0;
                        locked   <= 1'b1;
                    end
                end
                TRACK: begin
                    if (!dec.valid) begin
                        state  <= FAULT;
                        locked <= 1'b0;
                        fault  <= 1'b1;
                    end else if (dec.idx == prev_idx) begin
                        // stalled upstream counter: hold
                    end else if (is_succ) begin
                        units    <= dec.idx;
                        prev_idx <= dec.idx;
                    end else begin
`ifdef PHASE_SEQ_CHECK_EN
                        state  <= FAULT;
                        locked <= 1'b0;
                        fault  <= 1'b1;
`else
                        units    <= dec.idx;
                        prev_idx <= dec.idx;
`endif
                    end
                end
                FAULT: begin
                    locked <= 1'b0;
                    fault  <= 1'b1;
                end
                default: begin
                    state  <= FAULT;
                    locked <= 1'b0;
                    fault  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_decade_phase_tracker.sv
module tb_decade_phase_tracker;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] phase = 10'd0;
    logic       clr = 1'b0;
    logic [3:0] units;
    logic [7:0] decades;
    logic       locked;
    logic       fault;
    logic       wrap;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [3:0] u;
        logic [7:0] d;
        logic       l;
        logic       f;
        logic       w;
        string      nm;
    } exp_t;

    exp_t sb[$];

    // Reference count: units digit and decade count 0..99 as plain integers.
    int m_units = 0;
    int m_dec   = 0;

    decade_phase_tracker #(.NDEC(2)) dut (
        .clk     (clk),
        .rst     (rst),
        .phase   (phase),
        .clr     (clr),
        .units   (units),
        .decades (decades),
        .locked  (locked),
        .fault   (fault),
        .wrap    (wrap)
    );

    always #5 clk = ~clk;

    function automatic logic [9:0] oh(input int i);
        logic [9:0] one;
        one = 10'd1;
        return one << i;
    endfunction

    function automatic logic [7:0] bcd2(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    task automatic drive(input logic [9:0] ph, input logic c, input logic [3:0] eu,
                         input logic [7:0] ed, input logic el, input logic ef,
                         input logic ew, input string nm);
        exp_t e;
        @(negedge clk);
        phase = ph;
        clr   = c;
        e.u = eu; e.d = ed; e.l = el; e.f = ef; e.w = ew; e.nm = nm;
        sb.push_back(e);
    endtask

    task automatic adv(input int idx);
        logic w;
        w = 1'b0;
        m_units = idx;
        if (idx == 0) begin
            m_dec++;
            if (m_dec == 100) begin
                m_dec = 0;
                w = 1'b1;
            end
        end
        drive(oh(idx), 1'b0, 4'(m_units), bcd2(m_dec), 1'b1, 1'b0, w, "step");
    endtask

    task automatic m_reset();
        m_units = 0;
        m_dec   = 0;
    endtask

    task automatic chk_zero(input string nm);
        checks++;
        if (units !== 4'd0 || decades !== 8'd0 || locked !== 1'b0 || fault !== 1'b0 || wrap !== 1'b0) begin
            failures++;
            $display("FAIL %s: units=%0d decades=%h locked=%b fault=%b wrap=%b, required all zero",
                     nm, units, decades, locked, fault, wrap);
        end
    endtask

    // Monitor: every output cycle with a pending expectation is compared.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                if (units !== e.u || decades !== e.d || locked !== e.l || fault !== e.f || wrap !== e.w) begin
                    failures++;
                    $display("FAIL %s @%0t: units=%0d decades=%h locked=%b fault=%b wrap=%b, required units=%0d decades=%h locked=%b fault=%b wrap=%b",
                             e.nm, $time, units, decades, locked, fault, wrap, e.u, e.d, e.l, e.f, e.w);
                end
            end
        end
    end

    initial begin
        #500000;
        failures++;
        $display("FAIL timeout: simulation exceeded time budget");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

    initial begin
        #1;
        chk_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        // SYNC ignores everything but a0
        drive(oh(5),  1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 1'b0, "sync_ignore_a5");
        drive(10'd0,  1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 1'b0, "sync_ignore_zero");
        drive(oh(0),  1'b0, 4'd0, 8'h00, 1'b1, 1'b0, 1'b0, "lock");

        // 1000 steps from lock: exactly one wrap on the last step
        for (int r = 0; r < 100; r++) begin
            for (int k = 1; k <= 10; k++) begin
                adv(k % 10);
            end
        end

        // stalled counter
        adv(1); adv(2); adv(3);
        drive(oh(3), 1'b0, 4'd3, bcd2(m_dec), 1'b1, 1'b0, 1'b0, "stall_hold");
        adv(4);

        for (int k = 5; k <= 10; k++) adv(k % 10);
        adv(1); adv(2); adv(3);

`ifdef PHASE_SEQ_CHECK_EN
        drive(oh(6), 1'b0, 4'd3, bcd2(m_dec), 1'b0, 1'b1, 1'b0, "seq_fault");
        drive(oh(7), 1'b0, 4'd3, bcd2(m_dec), 1'b0, 1'b1, 1'b0, "seq_fault_frozen");
        drive(oh(7), 1'b1, 4'd0, 8'h00, 1'b0, 1'b0, 1'b0, "clr_after_seq_fault");
        m_reset();
        drive(oh(0), 1'b0, 4'd0, 8'h00, 1'b1, 1'b0, 1'b0, "relock");
        for (int k = 1; k <= 7; k++) adv(k);
`else
        drive(oh(6), 1'b0, 4'd6, bcd2(m_dec), 1'b1, 1'b0, 1'b0, "resync");
        m_units = 6;
        adv(7);
`endif

        // illegal code in TRACK
        drive(10'd0, 1'b0, 4'd7, bcd2(m_dec), 1'b0, 1'b1, 1'b0, "illegal_fault");
        drive(oh(8), 1'b0, 4'd7, bcd2(m_dec), 1'b0, 1'b1, 1'b0, "fault_frozen");
        drive(10'b0000011000, 1'b0, 4'd7, bcd2(m_dec), 1'b0, 1'b1, 1'b0, "fault_multihot");
        drive(oh(8), 1'b1, 4'd0, 8'h00, 1'b0, 1'b0, 1'b0, "clr_from_fault");
        m_reset();
        drive(oh(4), 1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 1'b0, "sync_after_clr");
        drive(oh(0), 1'b0, 4'd0, 8'h00, 1'b1, 1'b0, 1'b0, "relock2");
        adv(1); adv(2);

        // clr wins over an offending sample
        drive(10'd0, 1'b1, 4'd0, 8'h00, 1'b0, 1'b0, 1'b0, "clr_wins");
        m_reset();
        drive(oh(0), 1'b0, 4'd0, 8'h00, 1'b1, 1'b0, 1'b0, "relock3");

        // reach decades=5, units=7
        for (int r = 0; r < 5; r++) begin
            for (int k = 1; k <= 10; k++) adv(k % 10);
        end
        for (int k = 1; k <= 7; k++) adv(k);

        // async reset between edges
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk_zero("async_reset");
        @(negedge clk);
        rst = 1'b0;
        m_reset();
        drive(oh(4), 1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 1'b0, "sync_after_rst");
        drive(oh(0), 1'b0, 4'd0, 8'h00, 1'b1, 1'b0, 1'b0, "relock4");
        adv(1);

        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain: pending=%0d required 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
